apple_video_fetch: RTL

- Scanline fetch engine that reads the FPGA shadow video memory (text and hires banks) through the memory block's video read port.
- On each line strobe it computes the Apple II interleaved row address for the current mode and page, issues 20 sequential 32-bit reads, and buffers the returned words.
- It streams the words to the pixel renderer over a valid/ready interface.

---
 rtl/apple_video_pkg.sv | 40 ++++
 rtl/video_fetch_fifo.sv | 95 +++++++++
 rtl/apple_video_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/apple_video_pkg.sv
// Shared types, constants and the Apple II scanline base-address helper for the video fetch engine.
package apple_video_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned WORDS_PER_LINE  = 20;
    localparam logic [15:0] TEXT_BASE       = 16'h0400;
    localparam logic [15:0] HIRES_BASE      = 16'h2000;
    localparam int unsigned MIXED_TEXT_LINE = 160;
    localparam int unsigned LINES           = 192;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        text;
    } pix_word_t;

    localparam int unsigned PIX_WORD_W = $bits(pix_word_t);

    // Interleaved row address: text uses character row r = y/8, hires uses y directly.
    function automatic logic [15:0] line_base(input logic is_text, input logic pg2,
                                              input logic [7:0] y);
        logic [4:0]  r;
        logic [15:0] base;
        r = y[7:3];
        if (is_text) begin
            base = TEXT_BASE + (pg2 ? TEXT_BASE : 16'h0000)
                 + 16'(r[2:0]) * 16'd128 + 16'(r[4:3]) * 16'd40;
        end else begin
            base = HIRES_BASE + (pg2 ? HIRES_BASE : 16'h0000)
                 + 16'(y[2:0]) * 16'd1024 + 16'(y[5:3]) * 16'd128 + 16'(y[7:6]) * 16'd40;
        end
        return base;
    endfunction

endpackage

// File: rtl/video_fetch_fifo.sv
// First-word-fall-through FIFO with a registered head word and synchronous flush.
module video_fetch_fifo
    import apple_video_pkg::*;
#(
    parameter int unsigned WIDTH = PIX_WORD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_logic,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             mem_we_c;
    logic             pop_c;

    // Head register refills from storage first, else straight from the write port.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mem_we_c    = 1'b0;
        pop_c       = out_valid_q & rd_en_i;

        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (!out_valid_q || pop_c) begin
            if (count_q != '0) begin
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + AW'(1);
                count_d     = count_q - CW'(1);
                if (wr_en_i) begin
                    mem_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q;
                end
            end else begin
                out_valid_d = wr_en_i;
                if (wr_en_i) begin
                    out_data_d = wr_data_i;
                end
            end
        end else if (wr_en_i) begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;

endmodule

// File: rtl/apple_video_fetch.sv
// Scanline fetch engine: reads 20 words of Apple II text/hires shadow memory per line
// and streams them to the renderer through a credit-limited FWFT buffer.
module apple_video_fetch
    import apple_video_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk_logic,
    input  logic        reset_i,
    input  logic        line_start_i,
    input  logic [7:0]  line_i,
    input  logic        text_mode_i,
    input  logic        mixed_mode_i,
    input  logic        hires_mode_i,
    input  logic        page2_i,
    input  logic        store80_i,
    output logic [15:0] video_address_o,
    output logic        video_rd_o,
    input  logic [31:0] video_data_i,
    output logic [31:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic        pix_last_o,
    output logic        pix_text_o,
    output logic        busy_o
);

    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned KW     = 5;

    fetch_state_t            state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [15:0]             base_q, base_d;
    logic                    text_q, text_d;
    logic                    rd_q, rd_d;
    logic [15:0]             addr_q, addr_d;
    logic                    last_q, last_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;
    logic [CRED_W-1:0]       cred_q, cred_d;
    logic                    busy_q, busy_d;

    logic                    line_ok_c;
    logic                    new_text_c;
    logic [15:0]             new_base_c;
    logic                    pop_c;
    logic                    flush_c;
    logic                    wr_c;
    logic [CRED_W-1:0]       cred_avail_c;
    pix_word_t               wr_word_c;

    logic                    fifo_valid;
    logic [PIX_WORD_W-1:0]   fifo_dout;
    pix_word_t               head_w;

    // Credits count every word issued but not yet handed to the renderer.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        text_d      = text_q;
        rd_d        = 1'b0;
        addr_d      = 16'h0000;
        last_d      = 1'b0;
        pipe_d      = READ_LATENCY'({pipe_q, rd_q});
        pipe_last_d = READ_LATENCY'({pipe_last_q, last_q});

        line_ok_c    = line_i < 8'(LINES);
        new_text_c   = text_mode_i | (mixed_mode_i & (line_i >= 8'(MIXED_TEXT_LINE)))
                     | ~hires_mode_i;
        new_base_c   = line_base(new_text_c, page2_i & ~store80_i, line_i);
        pop_c        = fifo_valid & pix_ready_i;
        flush_c      = line_start_i & (state_q != IDLE);
        wr_c         = pipe_q[READ_LATENCY-1] & ~flush_c;
        cred_avail_c = cred_q - CRED_W'(pop_c);

        wr_word_c.data = video_data_i;
        wr_word_c.last = pipe_last_q[READ_LATENCY-1];
        wr_word_c.text = text_q;

        case (state_q)
            FETCH: begin
                if (cred_avail_c < CRED_W'(FIFO_DEPTH)) begin
                    rd_d   = 1'b1;
                    addr_d = base_q + 16'({k_q, 1'b0});
                    last_d = (k_q == KW'(WORDS_PER_LINE - 1));
                    k_d    = k_q + KW'(1);
                    if (last_d) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cred_avail_c == '0) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A strobe discards any line in progress and issues word 0 of the new one at once.
        if (line_start_i) begin
            if (line_ok_c) begin
                state_d = FETCH;
                base_d  = new_base_c;
                text_d  = new_text_c;
                rd_d    = 1'b1;
                addr_d  = new_base_c;
                last_d  = 1'b0;
                k_d     = KW'(1);
            end else if (state_q != IDLE) begin
                state_d = IDLE;
                rd_d    = 1'b0;
                addr_d  = 16'h0000;
                last_d  = 1'b0;
                k_d     = '0;
            end
            if (line_ok_c || flush_c) begin
                cred_avail_c = '0;
                pipe_d       = '0;
                pipe_last_d  = '0;
            end
        end

        cred_d = cred_avail_c + CRED_W'(rd_d);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_logic) begin
        if (reset_i) begin
            state_q     <= IDLE;
            k_q         <= '0;
            base_q      <= 16'h0000;
            text_q      <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= 16'h0000;
            last_q      <= 1'b0;
            pipe_q      <= '0;
            pipe_last_q <= '0;
            cred_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            text_q      <= text_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            pipe_q      <= pipe_d;
            pipe_last_q <= pipe_last_d;
            cred_q      <= cred_d;
            busy_q      <= busy_d;
        end
    end

    video_fetch_fifo #(
        .WIDTH (PIX_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_logic (clk_logic),
        .reset_i   (reset_i),
        .flush_i   (flush_c),
        .wr_en_i   (wr_c),
        .wr_data_i (wr_word_c),
        .rd_en_i   (pix_ready_i),
        .valid_o   (fifo_valid),
        .data_o    (fifo_dout)
    );

    assign head_w          = fifo_dout;
    assign pix_data_o      = head_w.data;
    assign pix_last_o      = head_w.last;
    assign pix_text_o      = head_w.text;
    assign pix_valid_o     = fifo_valid;
    assign video_rd_o      = rd_q;
    assign video_address_o = addr_q;
    assign busy_o          = busy_q;

endmodule
